// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb shared types: FSM state and index-width helper.
// Imported by the arbiter top and its interface users.
package fifo_wr_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Producer/FIFO write-side bundle for fifo_wr_arb.
// master: the arbiter; slave: producers plus the FIFO.
interface fifo_wr_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int OW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_data;
  logic               fifo_full;
  logic               fifo_rd_en;
  logic               fifo_empty;
  logic [OW-1:0]      occ;

  modport master (
    input  req, data,
    input  fifo_full, fifo_rd_en, fifo_empty,
    output gnt, fifo_wr_en, fifo_data, occ
  );

  modport slave (
    output req, data,
    output fifo_full, fifo_rd_en, fifo_empty,
    input  gnt, fifo_wr_en, fifo_data, occ
  );
endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin finder: first set request at or above start, with wrap.
// Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] j;

  // Scan from farthest offset down so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(start_i) + i) % N);
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-bounded write scheduler for a small FIFO.
// FIFO_WR_ARB_HIPRI_EN: producer 0 gets strict priority.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fifo_wr_arb_if.master bus
);

  localparam int IW = idx_w(NREQ);
  localparam int BW = $clog2(BURST + 1);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam logic [NREQ-1:0] ONE = 1;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [BW-1:0] beats_q, beats_d;
  logic          prio_q, prio_d;
  logic [OW-1:0] occ_q, occ_d;

  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          in_burst;
  logic          own_req;
  logic          wr_en;
  logic          last_beat;
  logic          rd_ok;
  logic          hp_win;
  logic          preempt;
  logic          done;
  logic [IW-1:0] rr_next;

  rr_pick #(
    .N (NREQ),
    .IW(IW)
  ) u_pick (
    .req_i  (bus.req),
    .start_i(rr_q),
    .found_o(pick_vld),
    .idx_o  (pick_idx)
  );

  assign in_burst  = (state_q == ST_BURST);
  assign own_req   = bus.req[owner_q];
  assign wr_en     = in_burst && own_req
                   && !bus.fifo_full;
  assign last_beat = wr_en
                   && (beats_q == BW'(BURST - 1));
  assign rd_ok     = bus.fifo_rd_en
                   && !bus.fifo_empty;

`ifdef FIFO_WR_ARB_HIPRI_EN
  assign hp_win  = bus.req[0];
  assign preempt = bus.req[0] && (owner_q != '0);
`else
  assign hp_win  = 1'b0;
  assign preempt = 1'b0;
`endif

  assign done    = !own_req || last_beat || preempt;
  assign rr_next = (owner_q == IW'(NREQ - 1))
                 ? '0 : owner_q + 1'b1;

  assign bus.fifo_wr_en = wr_en;
  assign bus.gnt  = wr_en ? (ONE << owner_q) : '0;
  assign bus.fifo_data = in_burst
                       ? bus.data[owner_q*DW +: DW]
                       : '0;
  assign bus.occ  = occ_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beats_d = beats_q;
    rr_d    = rr_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BURST;
          beats_d = '0;
          if (hp_win) begin
            owner_d = '0;
            // A priority win that RR would not have
            // chosen must leave rr_ptr where it was.
            prio_d  = (pick_idx != '0);
          end else begin
            owner_d = pick_idx;
            prio_d  = 1'b0;
          end
        end
      end
      ST_BURST: begin
        if (wr_en) beats_d = beats_q + 1'b1;
        if (done) begin
          state_d = ST_IDLE;
          beats_d = '0;
          prio_d  = 1'b0;
          rr_d    = prio_q ? rr_q : rr_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (wr_en && !rd_ok
        && occ_q != OW'(DEPTH))
      occ_d = occ_q + 1'b1;
    else if (rd_ok && !wr_en
             && occ_q != '0)
      occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beats_q <= '0;
      prio_q  <= 1'b0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beats_q <= beats_d;
      prio_q  <= prio_d;
      occ_q   <= occ_d;
    end
  end

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (!rst)
    $onehot0(bus.gnt));

  a_gnt_wr: assert property (
    @(posedge clk) disable iff (!rst)
    (|bus.gnt) |-> bus.fifo_wr_en);

  a_occ_full: assert property (
    @(posedge clk) disable iff (!rst)
    (occ_q == OW'(DEPTH)) == bus.fifo_full);

  a_occ_empty: assert property (
    @(posedge clk) disable iff (!rst)
    (occ_q == '0) == bus.fifo_empty);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: FIFO model, reference arbiter model,
// per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int DEPTH = 4;
  localparam int OW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(
    .NREQ(NREQ), .DW(DW), .OW(OW)
  ) bus ();

  fifo_wr_arb #(
    .NREQ (NREQ),
    .DW   (DW),
    .BURST(BURST),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fcount  = 0;

  assign bus.fifo_full  = (fcount == DEPTH);
  assign bus.fifo_empty = (fcount == 0);

  // reference model state
  bit m_busy = 1'b0;
  bit m_prio = 1'b0;
  int m_own  = 0;
  int m_cnt  = 0;
  int m_ptr  = 0;
  bit m_w, m_stop, e_w;
  int m_p;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int first_from(
    input logic [NREQ-1:0] r, input int from);
    for (int k = 0; k < NREQ; k++)
      if (r[(from + k) % NREQ])
        return (from + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_prio = 0;
      m_own = 0; m_cnt = 0; m_ptr = 0;
      fcount <= 0;
    end else begin
      fcount <= fcount
        + ((bus.fifo_wr_en && fcount < DEPTH) ? 1 : 0)
        - ((bus.fifo_rd_en && fcount > 0) ? 1 : 0);
      m_w = m_busy && bus.req[m_own]
            && (fcount < DEPTH);
      if (!m_busy) begin
        m_p = first_from(bus.req, m_ptr);
        if (m_p >= 0) begin
          m_busy = 1; m_cnt = 0;
          m_own = m_p; m_prio = 0;
`ifdef FIFO_WR_ARB_HIPRI_EN
          if (bus.req[0] && m_p != 0) begin
            m_own = 0; m_prio = 1;
          end
`endif
        end
      end else begin
        if (m_w) m_cnt++;
        m_stop = !bus.req[m_own]
                 || (m_w && m_cnt == BURST);
`ifdef FIFO_WR_ARB_HIPRI_EN
        if (bus.req[0] && m_own != 0) m_stop = 1;
`endif
        if (m_stop) begin
          m_busy = 0;
          if (!m_prio) m_ptr = (m_own + 1) % NREQ;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      e_w = m_busy && bus.req[m_own]
            && (fcount < DEPTH);
      chk("cmp_gnt", int'(bus.gnt),
          e_w ? (1 << m_own) : 0);
      chk("cmp_wr_en", int'(bus.fifo_wr_en),
          int'(e_w));
      chk("cmp_data", int'(bus.fifo_data),
          m_busy ? int'(bus.data[m_own*DW +: DW]) : 0);
      chk("cmp_occ", int'(bus.occ), fcount);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.fifo_rd_en = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] e1 [8];
    logic [3:0] e6 [7];
    int g, mx;
    e1 = '{4'h0, 4'h1, 4'h1, 4'h1,
           4'h1, 4'h0, 4'h0, 4'h0};
`ifdef FIFO_WR_ARB_HIPRI_EN
    e6 = '{4'h0, 4'h8, 4'h8, 4'h0,
           4'h1, 4'h1, 4'h1};
`else
    e6 = '{4'h0, 4'h8, 4'h8, 4'h8,
           4'h8, 4'h0, 4'h1};
`endif
    bus.data = 32'hD3D2D1D0;
    bus.req  = '0;
    bus.fifo_rd_en = 1'b0;
    #1;

    // 1: single producer fills the FIFO
    do_reset();
    #1;
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_wr_en", int'(bus.fifo_wr_en), 0);
    chk("rst_data", int'(bus.fifo_data), 0);
    chk("rst_occ", int'(bus.occ), 0);
    bus.req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t1_gnt", int'(bus.gnt), int'(e1[c]));
      if (c == 1)
        chk("t1_data", int'(bus.fifo_data), 'hD0);
      if (c == 5)
        chk("t1_occ4", int'(bus.occ), 4);
      tick();
    end

    // 2: all request, consumer reads every cycle
    do_reset();
    bus.req = 4'b1111;
    bus.fifo_rd_en = 1'b1;
    mx = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
`ifdef FIFO_WR_ARB_HIPRI_EN
      g = (c >= 1 && (c - 1) % 5 < 4) ? 1 : 0;
`else
      g = (c >= 1 && (c - 1) % 5 < 4)
        ? (1 << (((c - 1) / 5) % 4)) : 0;
`endif
      chk("t2_gnt", int'(bus.gnt), g);
      if (int'(bus.occ) > mx) mx = int'(bus.occ);
      tick();
    end
    chk("t2_occ_max", mx, 1);

    // 3: full FIFO blocks owner 2 until one read
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t3_fill", int'(bus.gnt),
          (c >= 1 && c <= 4) ? 4 : 0);
      tick();
    end
    #1;
    chk("t3_full_gnt", int'(bus.gnt), 0);
    chk("t3_full_occ", int'(bus.occ), 4);
    tick();
    bus.fifo_rd_en = 1'b1;
    #1;
    chk("t3_rd_gnt", int'(bus.gnt), 0);
    tick();
    bus.fifo_rd_en = 1'b0;
    #1;
    chk("t3_beat_gnt", int'(bus.gnt), 4);
    chk("t3_beat_data", int'(bus.fifo_data), 'hD2);
    chk("t3_beat_occ", int'(bus.occ), 3);
    tick();
    #1;
    chk("t3_after_occ", int'(bus.occ), 4);
    chk("t3_after_gnt", int'(bus.gnt), 0);

    // 4: simultaneous read/write; read when empty
    do_reset();
    bus.req = 4'b0001;
    tick(); tick(); tick();
    bus.fifo_rd_en = 1'b1;
    #1;
    chk("t4_occ2", int'(bus.occ), 2);
    chk("t4_rw_gnt", int'(bus.gnt), 1);
    tick();
    bus.req = 4'b0000;
    #1;
    chk("t4_occ_hold", int'(bus.occ), 2);
    tick(); tick();
    #1;
    chk("t4_occ0", int'(bus.occ), 0);
    chk("t4_empty", int'(bus.fifo_empty), 1);
    tick();
    #1;
    chk("t4_occ0_rd", int'(bus.occ), 0);
    bus.fifo_rd_en = 1'b0;

    // 5: reset mid-burst, then scan from 0
    do_reset();
    bus.req = 4'b0001;
    bus.fifo_rd_en = 1'b1;
    tick(); tick(); tick();
    #1;
    chk("t5_pre_gnt", int'(bus.gnt), 1);
    rst = 1'b0;
    #1;
    chk("t5_rst_gnt", int'(bus.gnt), 0);
    chk("t5_rst_wr", int'(bus.fifo_wr_en), 0);
    chk("t5_rst_data", int'(bus.fifo_data), 0);
    chk("t5_rst_occ", int'(bus.occ), 0);
    tick();
    rst = 1'b1;
    bus.req = 4'b0100;
    #1;
    chk("t5_idle_gnt", int'(bus.gnt), 0);
    tick();
    #1;
    chk("t5_p2_gnt", int'(bus.gnt), 4);
    chk("t5_p2_data", int'(bus.fifo_data), 'hD2);

    // 6: producer 3 bursting, req[0] rises
    do_reset();
    bus.req = 4'b1000;
    bus.fifo_rd_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) bus.req = 4'b1001;
      #1;
      chk("t6_gnt", int'(bus.gnt), int'(e6[c]));
      tick();
    end

    bus.req = '0;
    bus.fifo_rd_en = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
